// File: rtl/memory_dump_unit_pkg.sv
// -----------------------------------------------------------------------------
// memory_dump_unit_pkg
// Shared debug definitions for the memory dump path: FSM state encoding,
// byte-stream handshake type and word/byte sizing helpers. Imported by
// word_byte_serializer and memory_dump_unit.
// Optional feature macro: DUMP_CHECKSUM_EN (adds the CHKSUM state).
// -----------------------------------------------------------------------------
package memory_dump_unit_pkg;

   localparam int BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Byte stream toward the UART transmitter. A byte transfers on a clock
   // edge where valid and the transmitter's ready are both high; ready flows
   // back on its own wire.
   typedef struct packed {
      byte_t data;
      logic  valid;
   } byte_stream_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET_ADDR,
      ST_CAPTURE,
      ST_SEND,
      ST_NEXT,
`ifdef DUMP_CHECKSUM_EN
      ST_CHKSUM,
`endif
      ST_DONE
   } dump_state_t;

   function automatic int bytes_per_word(input int bits);
      return bits / BYTE_W;
   endfunction

   // Counter width able to index n items (never narrower than one bit).
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/memory_dump_unit_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Holds one captured memory word and walks through its bytes MSB first.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture 'word' and restart at the most significant byte
//   word        memory word to capture
//   advance     current byte was accepted; move to the next one
//   peek_byte   byte that will be current after this edge (lets the parent
//               register its output byte without an extra cycle)
//   last        current byte is the least significant one
// -----------------------------------------------------------------------------
module word_byte_serializer
   import memory_dump_unit_pkg::*;
#(
   parameter int BITS_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [BITS_SIZE-1:0] word,
   input  logic                 advance,
   output byte_t                peek_byte,
   output logic                 last
);

   localparam int BYTES_PER_WORD = bytes_per_word(BITS_SIZE);
   localparam int CNT_W          = index_width(BYTES_PER_WORD);

   logic [BITS_SIZE-1:0] word_reg;
   logic [CNT_W-1:0]     byte_cnt;
   logic [BITS_SIZE-1:0] peek_word;
   logic [CNT_W-1:0]     peek_idx;

   assign last = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_reg <= '0;
         byte_cnt <= '0;
      end else if (load) begin
         word_reg <= word;
         byte_cnt <= '0;
      end else if (advance && !last) begin
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

   // NOTE: defaults first, so every path assigns every output and no latch
   // is inferred.
   always_comb begin
      peek_word = word_reg;
      peek_idx  = byte_cnt;
      if (load) begin
         peek_word = word;
         peek_idx  = '0;
      end else if (advance && !last) begin
         peek_idx = byte_cnt + 1'b1;
      end
      peek_byte = peek_word[(BYTES_PER_WORD - 1 - int'(peek_idx)) * BYTE_W +: BYTE_W];
   end

endmodule

// File: rtl/memory_dump_unit.sv
// -----------------------------------------------------------------------------
// memory_dump_unit
// Reads every word of the data memory through its debug port and streams it
// MSB byte first to the debug UART transmitter over a valid/ready byte link.
// Ports:
//   i_clk, i_reset   clock; asynchronous active-low reset
//   i_start          start a dump (only looked at while idle)
//   o_debug_address  word address to the memory debug port
//   i_debug_data     memory word at o_debug_address (combinational read)
//   o_tx_data        byte to transmitter
//   o_tx_valid       o_tx_data valid
//   i_tx_ready       transmitter accepts the byte when valid and ready
//   o_busy           high whenever a dump is in progress
//   o_done           one-cycle pulse after the final byte
// Optional feature macro: DUMP_CHECKSUM_EN appends one byte holding the XOR of
// every byte sent in the dump.
// -----------------------------------------------------------------------------
module memory_dump_unit
   import memory_dump_unit_pkg::*;
#(
   parameter int BITS_SIZE     = 32,
   parameter int SIZE_MEM_DATA = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   output logic [BITS_SIZE-1:0] o_debug_address,
   input  logic [BITS_SIZE-1:0] i_debug_data,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [BITS_SIZE-1:0] LAST_ADDR = BITS_SIZE'(SIZE_MEM_DATA - 1);

   dump_state_t          state;
   logic [BITS_SIZE-1:0] addr;
   byte_stream_t         tx;
   logic                 busy;
   logic                 done;
`ifdef DUMP_CHECKSUM_EN
   byte_t                chk;
`endif

   logic  load;
   logic  advance;
   logic  last;
   byte_t peek_byte;

   assign load    = (state == ST_CAPTURE);
   assign advance = (state == ST_SEND) && i_tx_ready;

   word_byte_serializer #(
      .BITS_SIZE (BITS_SIZE)
   ) u_serializer (
      .clk       (i_clk),
      .rst_n     (i_reset),
      .load      (load),
      .word      (i_debug_data),
      .advance   (advance),
      .peek_byte (peek_byte),
      .last      (last)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
         addr  <= '0;
         tx    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         chk   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  addr  <= '0;
                  busy  <= 1'b1;
                  state <= ST_SET_ADDR;
`ifdef DUMP_CHECKSUM_EN
                  chk   <= '0;
`endif
               end
            end

            // Give the memory read one cycle to settle on the new address.
            ST_SET_ADDR: state <= ST_CAPTURE;

            // The serializer captures the word on this edge; present its MSB.
            ST_CAPTURE: begin
               tx.data  <= peek_byte;
               tx.valid <= 1'b1;
               state    <= ST_SEND;
            end

            ST_SEND: begin
               if (i_tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                  chk <= chk ^ tx.data;
`endif
                  if (last) begin
                     tx.valid <= 1'b0;
                     state    <= ST_NEXT;
                  end else begin
                     tx.data <= peek_byte;
                  end
               end
            end

            ST_NEXT: begin
               if (addr == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
                  tx.data  <= chk;
                  tx.valid <= 1'b1;
                  state    <= ST_CHKSUM;
`else
                  done     <= 1'b1;
                  state    <= ST_DONE;
`endif
               end else begin
                  addr  <= addr + 1'b1;
                  state <= ST_SET_ADDR;
               end
            end

`ifdef DUMP_CHECKSUM_EN
            ST_CHKSUM: begin
               if (i_tx_ready) begin
                  tx.valid <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end
            end
`endif

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_debug_address = addr;
   assign o_tx_data       = tx.data;
   assign o_tx_valid      = tx.valid;
   assign o_busy          = busy;
   assign o_done          = done;

endmodule
